// File: rtl/change_dispenser_pkg.sv
// ---------------------------------------------------------------------------
// change_dispenser_pkg
// Shared definitions for the change dispenser:
//   - denomination codes (00=1, 01=2, 10=5, 11=10 yuan)
//   - denom_value(): code -> coin value in yuan
//   - state_e: FSM state encoding
//   - MAX_STOCK: default per-denomination stock ceiling (fits 4 bits)
// ---------------------------------------------------------------------------
package change_dispenser_pkg;

    localparam logic [1:0] DENOM_1  = 2'b00;
    localparam logic [1:0] DENOM_2  = 2'b01;
    localparam logic [1:0] DENOM_5  = 2'b10;
    localparam logic [1:0] DENOM_10 = 2'b11;

    localparam int unsigned MAX_STOCK = 15;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

    function automatic logic [6:0] denom_value(input logic [1:0] code);
        logic [6:0] v;
        case (code)
            DENOM_1:  v = 7'd1;
            DENOM_2:  v = 7'd2;
            DENOM_5:  v = 7'd5;
            default:  v = 7'd10;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_coin_picker.sv
// ---------------------------------------------------------------------------
// coin_picker
// Combinational greedy selector: returns the largest denomination whose value
// does not exceed the amount still owed and which has at least one coin left.
// Ports:
//   remaining      in  7  change still owed
//   stock0..stock3 in  4  stock of 1, 2, 5, 10 yuan coins
//   found          out 1  a usable denomination exists
//   code           out 2  denomination code of the chosen coin (valid with found)
// ---------------------------------------------------------------------------
module coin_picker
    import change_dispenser_pkg::*;
(
    input  logic [6:0] remaining,
    input  logic [3:0] stock0,
    input  logic [3:0] stock1,
    input  logic [3:0] stock2,
    input  logic [3:0] stock3,
    output logic       found,
    output logic [1:0] code
);

    // Priority from largest value down; the value test guarantees that the
    // subtraction done on acknowledge can never underflow.
    always_comb begin
        found = 1'b0;
        code  = DENOM_1;
        if ((stock3 != 4'd0) && (remaining >= 7'd10)) begin
            found = 1'b1;
            code  = DENOM_10;
        end else if ((stock2 != 4'd0) && (remaining >= 7'd5)) begin
            found = 1'b1;
            code  = DENOM_5;
        end else if ((stock1 != 4'd0) && (remaining >= 7'd2)) begin
            found = 1'b1;
            code  = DENOM_2;
        end else if ((stock0 != 4'd0) && (remaining >= 7'd1)) begin
            found = 1'b1;
            code  = DENOM_1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Pays out an amount of change one coin at a time through an external coin
// mechanism, picking the largest usable denomination for every coin.
//
// Coin handshake: coin_req rises one cycle after ISSUE with coin_sel already
// registered; both stay stable until coin_ack is sampled high in WAIT_ACK.
// coin_ack outside WAIT_ACK is ignored. After each ack coin_req is low for at
// least two cycles (SELECT, ISSUE) before the next coin is requested. If no
// ack arrives within ACK_TIMEOUT cycles the block parks in FAULT.
//
// Ports:
//   clk         in  1  clock, rising edge
//   rst_n       in  1  asynchronous reset, ACTIVE HIGH despite the name
//   start       in  1  pay out change_amt (taken only in IDLE)
//   change_amt  in  7  amount to pay, 0..127
//   coin_ack    in  1  mechanism ejected one coin of coin_sel
//   refill_en   in  1  add refill_qty coins of refill_sel (taken only in IDLE)
//   refill_sel  in  2  denomination code for refill
//   refill_qty  in  4  number of coins to add (saturates at MAX_STOCK)
//   busy        out 1  payout in progress (start accepted .. DONE exited)
//   coin_req    out 1  request one coin of coin_sel
//   coin_sel    out 2  denomination of the pending coin
//   remaining   out 7  change still owed
//   done        out 1  one-cycle end-of-payout pulse
//   short_chg   out 1  payout ended with remaining > 0; held until next start
//   fault       out 1  sticky ack-timeout flag
//   stock0..3   out 4  coin stock for 1, 2, 5, 10 yuan
//   state_dbg   out 3  current FSM state (state_e encoding)
// ---------------------------------------------------------------------------
module change_dispenser #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned MAX_STOCK   = change_dispenser_pkg::MAX_STOCK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] change_amt,
    input  logic       coin_ack,
    input  logic       refill_en,
    input  logic [1:0] refill_sel,
    input  logic [3:0] refill_qty,
    output logic       busy,
    output logic       coin_req,
    output logic [1:0] coin_sel,
    output logic [6:0] remaining,
    output logic       done,
    output logic       short_chg,
    output logic       fault,
    output logic [3:0] stock0,
    output logic [3:0] stock1,
    output logic [3:0] stock2,
    output logic [3:0] stock3,
    output logic [2:0] state_dbg
);

    import change_dispenser_pkg::*;

    localparam logic [2:0] S_IDLE     = ST_IDLE;
    localparam logic [2:0] S_SELECT   = ST_SELECT;
    localparam logic [2:0] S_ISSUE    = ST_ISSUE;
    localparam logic [2:0] S_WAIT_ACK = ST_WAIT_ACK;
    localparam logic [2:0] S_DONE     = ST_DONE;
    localparam logic [2:0] S_FAULT    = ST_FAULT;

    localparam int unsigned TW        = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [4:0]    STOCK_CAP = 5'(MAX_STOCK);

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [3:0]    stock [4];

    logic          pick_found;
    logic [1:0]    pick_code;
    logic [4:0]    refill_sum;
    logic [3:0]    refill_sat;

    coin_picker u_coin_picker (
        .remaining (remaining),
        .stock0    (stock[0]),
        .stock1    (stock[1]),
        .stock2    (stock[2]),
        .stock3    (stock[3]),
        .found     (pick_found),
        .code      (pick_code)
    );

    // Five-bit sum so a large refill saturates instead of wrapping.
    always_comb begin
        refill_sum = {1'b0, stock[refill_sel]} + {1'b0, refill_qty};
        refill_sat = (refill_sum > STOCK_CAP) ? STOCK_CAP[3:0] : refill_sum[3:0];
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            remaining <= 7'd0;
            busy      <= 1'b0;
            coin_req  <= 1'b0;
            coin_sel  <= DENOM_1;
            done      <= 1'b0;
            short_chg <= 1'b0;
            fault     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stock[i] <= 4'd0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Refill and start may coincide; the stock update lands on
                    // the same edge, so SELECT already sees the new count.
                    if (refill_en) begin
                        stock[refill_sel] <= refill_sat;
                    end
                    if (start) begin
                        remaining <= change_amt;
                        busy      <= 1'b1;
                        short_chg <= 1'b0;
                        state     <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (remaining == 7'd0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (pick_found) begin
                        coin_sel <= pick_code;
                        state    <= S_ISSUE;
                    end else begin
                        short_chg <= 1'b1;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_ISSUE: begin
                    coin_req <= 1'b1;
                    timer    <= '0;
                    state    <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (coin_ack) begin
                        remaining       <= remaining - denom_value(coin_sel);
                        stock[coin_sel] <= stock[coin_sel] - 4'd1;
                        coin_req        <= 1'b0;
                        state           <= S_SELECT;
                    end else if (timer == T_LAST) begin
                        // coin_req has now been up ACK_TIMEOUT cycles unanswered.
                        coin_req <= 1'b0;
                        fault    <= 1'b1;
                        state    <= S_FAULT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_FAULT: begin
                    // Parked until reset: busy stays high, remaining frozen.
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign stock0    = stock[0];
    assign stock1    = stock[1];
    assign stock2    = stock[2];
    assign stock3    = stock[3];
    assign state_dbg = state;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] change_amt;
    logic       coin_ack;
    logic       refill_en;
    logic [1:0] refill_sel;
    logic [3:0] refill_qty;
    logic       busy, coin_req, done, short_chg, fault;
    logic [1:0] coin_sel;
    logic [6:0] remaining;
    logic [3:0] stock0, stock1, stock2, stock3;
    logic [2:0] state_dbg;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    change_dispenser #(.ACK_TIMEOUT(255), .MAX_STOCK(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .change_amt (change_amt),
        .coin_ack   (coin_ack),
        .refill_en  (refill_en),
        .refill_sel (refill_sel),
        .refill_qty (refill_qty),
        .busy       (busy),
        .coin_req   (coin_req),
        .coin_sel   (coin_sel),
        .remaining  (remaining),
        .done       (done),
        .short_chg  (short_chg),
        .fault      (fault),
        .stock0     (stock0),
        .stock1     (stock1),
        .stock2     (stock2),
        .stock3     (stock3),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int tests  = 0;
    int errors = 0;
    logic [1:0] exp_q[$];       // expected coin codes, in order
    logic [7:0] exp_done_q[$];  // expected {short_chg, remaining} at done
    logic       ack_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every new coin request and every done pulse is checked
    // against the expected queues.
    logic       prev_req = 1'b0;
    logic [1:0] prev_sel = 2'b00;
    always @(negedge clk) begin
        if (coin_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                check("unexpected_coin", {30'd0, coin_sel}, 32'hffff_ffff);
            end else begin
                check("coin_sel", {30'd0, coin_sel}, {30'd0, exp_q.pop_front()});
            end
        end
        if (coin_req && prev_req && (coin_sel !== prev_sel)) begin
            check("coin_sel_stable", {30'd0, coin_sel}, {30'd0, prev_sel});
        end
        if (done) begin
            if (exp_done_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                check("done_result", {24'd0, short_chg, remaining}, {24'd0, exp_done_q.pop_front()});
            end
        end
        prev_req = coin_req;
        prev_sel = coin_sel;
    end

    // Coin mechanism model: acknowledges each request after 0..3 cycles.
    always begin
        @(negedge clk);
        if (ack_en && coin_req) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (coin_req) coin_ack = 1'b1;
            @(negedge clk);
            coin_ack = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_refill(input logic [1:0] sel, input logic [3:0] qty);
        refill_en  = 1'b1;
        refill_sel = sel;
        refill_qty = qty;
        @(negedge clk);
        refill_en  = 1'b0;
    endtask

    task automatic do_start(input logic [6:0] amt);
        start      = 1'b1;
        change_amt = amt;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finish"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!coin_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req_seen"}, {31'd0, coin_req}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_coin_req"},  {31'd0, coin_req},  32'd0);
        check({tag, "_done"},      {31'd0, done},      32'd0);
        check({tag, "_short"},     {31'd0, short_chg}, 32'd0);
        check({tag, "_fault"},     {31'd0, fault},     32'd0);
        check({tag, "_coin_sel"},  {30'd0, coin_sel},  32'd0);
        check({tag, "_remaining"}, {25'd0, remaining}, 32'd0);
        check({tag, "_stocks"},    {16'd0, stock3, stock2, stock1, stock0}, 32'd0);
        check({tag, "_state"},     {29'd0, state_dbg}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b1; start = 1'b0; change_amt = 7'd0; coin_ack = 1'b0;
        refill_en = 1'b0; refill_sel = 2'd0; refill_qty = 4'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Greedy payout of 18 from five of each coin.
        for (int i = 0; i < 4; i++) do_refill(2'(i), 4'd5);
        check("refill5", {16'd0, stock3, stock2, stock1, stock0}, 32'h5555);
        exp_q.push_back(2'd3); exp_q.push_back(2'd2);
        exp_q.push_back(2'd1); exp_q.push_back(2'd0);
        exp_done_q.push_back({1'b0, 7'd0});
        do_start(7'd18);
        wait_idle("pay18");
        check("pay18_stocks", {16'd0, stock3, stock2, stock1, stock0}, 32'h4444);

        // Saturating refill: 4 + 8 = 12, then 12 + 9 clips at 15.
        do_refill(2'd0, 4'd8);
        check("refill_12", {28'd0, stock0}, 32'd12);
        do_refill(2'd0, 4'd9);
        check("refill_sat", {28'd0, stock0}, 32'd15);

        // Short change: only 2-yuan coins for an amount of 5.
        do_reset();
        do_refill(2'd1, 4'd3);
        exp_q.push_back(2'd1); exp_q.push_back(2'd1);
        exp_done_q.push_back({1'b1, 7'd1});
        do_start(7'd5);
        wait_idle("short5");
        check("short5_remaining", {25'd0, remaining}, 32'd1);
        check("short5_held",      {31'd0, short_chg}, 32'd1);
        check("short5_stock1",    {28'd0, stock1},    32'd1);

        // Refill and start ignored while busy. Stocks {0,1,0,2}, pay 25:
        // 10, 10, 2 -> 3 left, no usable coin.
        do_refill(2'd3, 4'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd3); exp_q.push_back(2'd1);
        exp_done_q.push_back({1'b1, 7'd3});
        do_start(7'd25);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        refill_en = 1'b1; refill_sel = 2'd0; refill_qty = 4'd7;
        start = 1'b1; change_amt = 7'd9;
        repeat (3) @(negedge clk);
        refill_en = 1'b0; start = 1'b0;
        wait_idle("pay25");
        check("pay25_stocks", {16'd0, stock3, stock2, stock1, stock0}, 32'h0000);
        check("pay25_remaining", {25'd0, remaining}, 32'd3);

        // Zero amount: done exactly two cycles after start, no coin.
        exp_done_q.push_back({1'b0, 7'd0});
        do_start(7'd0);
        check("zero_done_early", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("zero_done_at2", {31'd0, done}, 32'd1);
        check("zero_no_coin", {31'd0, coin_req}, 32'd0);
        @(negedge clk);
        check("zero_idle", {31'd0, busy}, 32'd0);

        // Ack timeout.
        ack_en = 1'b0;
        do_reset();
        do_refill(2'd0, 4'd2);
        exp_q.push_back(2'd0);
        do_start(7'd1);
        wait_req("tmo");
        begin
            int cnt = 0;
            while (coin_req && cnt < 400) begin
                cnt++;
                @(negedge clk);
            end
            check("tmo_req_cycles", cnt, 32'd255);
        end
        check("tmo_fault",    {31'd0, fault},    32'd1);
        check("tmo_coin_req", {31'd0, coin_req}, 32'd0);
        check("tmo_busy",     {31'd0, busy},     32'd1);
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("tmo_late_ack_rem",   {25'd0, remaining}, 32'd1);
        check("tmo_late_ack_stock", {28'd0, stock0},    32'd2);
        check("tmo_late_ack_req",   {31'd0, coin_req},  32'd0);
        check("tmo_state",          {29'd0, state_dbg}, 32'd5);
        check("tmo_still_fault",    {31'd0, fault},     32'd1);

        // Asynchronous reset while waiting for ack.
        do_reset();
        do_refill(2'd2, 4'd1);
        exp_q.push_back(2'd2);
        do_start(7'd7);
        wait_req("rst_mid");
        #2 rst_n = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_no_req", {31'd0, coin_req}, 32'd0);

        check("coin_q_empty", exp_q.size(), 32'd0);
        check("done_q_empty", exp_done_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
